dp_ram_be: RTL and testbench

Parametrised true dual-port synchronous RAM. It is the successor to the team's combinational-read dual-port RAM. It adds per-byte write enables, per-port access enables, a registered read pipeline of 1 or 2 cycles with a valid flag, a selectable read-during-write mode, and same-address collision detection. It serves as the shared instruction/data memory and as scratch buffers between the core and DMA/peripheral masters.

---
 rtl/dp_ram_be.sv | 183 ++++++++++++++++++
 tb/tb_dp_ram_be.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte write enables, 1- or 2-cycle registered reads and collision flag.
// Optional per-lane even parity is built when DP_RAM_PARITY_EN is defined.
module dp_ram_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 4096,
    parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0,
    localparam int BYTE_LANES  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic [BYTE_LANES-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic [BYTE_LANES-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  valid_b,
    output logic                  collision,
    output logic                  parity_err
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  in_range_a, in_range_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, rd_a, rd_b;
    logic [DATA_WIDTH-1:0] s1_data_a, s1_data_b;
    logic                  s1_valid_a, s1_valid_b;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BYTE_LANES-1:0] lanes
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    // Only a non-power-of-two depth can see addresses past the end of the array.
    generate
        if ((1 << ADDR_WIDTH) == MEM_DEPTH) begin : g_full_depth
            assign in_range_a = 1'b1;
            assign in_range_b = 1'b1;
        end else begin : g_partial_depth
            assign in_range_a = (32'(addr_a) < MEM_DEPTH);
            assign in_range_b = (32'(addr_b) < MEM_DEPTH);
        end
    endgenerate

    always_comb begin
        old_a = in_range_a ? mem[addr_a] : '0;
        old_b = in_range_b ? mem[addr_b] : '0;
        rd_a  = old_a;
        rd_b  = old_b;
        if (WRITE_FIRST != 0) begin
            if (in_range_a) rd_a = merge_lanes(old_a, din_a, we_a);
            if (in_range_b) rd_b = merge_lanes(old_b, din_b, we_b);
        end
    end

    // Port A is applied last so it owns any lane both ports write at the same address.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (en_b && in_range_b && we_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
                if (en_a && in_range_a && we_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_a <= 1'b0;
            s1_valid_b <= 1'b0;
            s1_data_a  <= '0;
            s1_data_b  <= '0;
            collision  <= 1'b0;
        end else begin
            s1_valid_a <= en_a;
            s1_valid_b <= en_b;
            if (en_a) s1_data_a <= rd_a;
            if (en_b) s1_data_b <= rd_b;
            collision  <= en_a && en_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data_a, s2_data_b;
            logic                  s2_valid_a, s2_valid_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_a <= 1'b0;
                    s2_valid_b <= 1'b0;
                    s2_data_a  <= '0;
                    s2_data_b  <= '0;
                end else begin
                    s2_valid_a <= s1_valid_a;
                    s2_valid_b <= s1_valid_b;
                    if (s1_valid_a) s2_data_a <= s1_data_a;
                    if (s1_valid_b) s2_data_b <= s1_data_b;
                end
            end

            assign dout_a  = s2_data_a;
            assign dout_b  = s2_data_b;
            assign valid_a = s2_valid_a;
            assign valid_b = s2_valid_b;
        end else begin : g_lat1
            assign dout_a  = s1_data_a;
            assign dout_b  = s1_data_b;
            assign valid_a = s1_valid_a;
            assign valid_b = s1_valid_b;
        end
    endgenerate

`ifdef DP_RAM_PARITY_EN
    logic [BYTE_LANES-1:0] par_mem [MEM_DEPTH];
    logic [BYTE_LANES-1:0] exp_par_a, exp_par_b;
    logic                  bad_a, bad_b, perr_s1;

    function automatic logic [BYTE_LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] word);
        logic [BYTE_LANES-1:0] p;
        for (int i = 0; i < BYTE_LANES; i++) p[i] = ^word[8*i +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (en_b && in_range_b && we_b[i]) par_mem[addr_b][i] <= ^din_b[8*i +: 8];
                if (en_a && in_range_a && we_a[i]) par_mem[addr_a][i] <= ^din_a[8*i +: 8];
            end
        end
    end

    // Written-through lanes carry freshly computed parity, so they can never flag.
    always_comb begin
        exp_par_a = in_range_a ? par_mem[addr_a] : '0;
        exp_par_b = in_range_b ? par_mem[addr_b] : '0;
        if (WRITE_FIRST != 0) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (in_range_a && we_a[i]) exp_par_a[i] = ^din_a[8*i +: 8];
                if (in_range_b && we_b[i]) exp_par_b[i] = ^din_b[8*i +: 8];
            end
        end
        bad_a = en_a && (lane_parity(rd_a) != exp_par_a);
        bad_b = en_b && (lane_parity(rd_b) != exp_par_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_s1 <= 1'b0;
        else        perr_s1 <= bad_a || bad_b;
    end

    generate
        if (READ_LATENCY == 2) begin : g_par_lat2
            logic perr_s2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) perr_s2 <= 1'b0;
                else        perr_s2 <= perr_s1;
            end
            assign parity_err = perr_s2;
        end else begin : g_par_lat1
            assign parity_err = perr_s1;
        end
    endgenerate
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dp_ram_be.sv
// Self-checking bench for dp_ram_be: two instances (latency 1 write-first, latency 2 read-first)
// share one stimulus stream and are compared against a word-level reference memory.
module tb_dp_ram_be;

    localparam int DW    = 32;
    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int BL    = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_a, en_b;
    logic [BL-1:0] we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    logic [DW-1:0] dout_a [2];
    logic [DW-1:0] dout_b [2];
    logic          valid_a [2];
    logic          valid_b [2];
    logic          collision [2];
    logic          parity_err [2];

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents plus, per instance and port, the accesses still in flight.
    logic [DW-1:0] ref_mem [16];
    bit            written [16];
    bit            pipe_v [2][2][2];
    logic [DW-1:0] pipe_d [2][2][2];
    bit            pipe_k [2][2][2];
    bit            exp_v [2][2];
    logic [DW-1:0] exp_d [2][2];
    bit            exp_k [2][2];
    bit            exp_col;

    dp_ram_be #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .READ_LATENCY(1), .WRITE_FIRST(1)
    ) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a[0]), .valid_a(valid_a[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b[0]), .valid_b(valid_b[0]),
        .collision(collision[0]), .parity_err(parity_err[0])
    );

    dp_ram_be #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .READ_LATENCY(2), .WRITE_FIRST(0)
    ) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a[1]), .valid_a(valid_a[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b[1]), .valid_b(valid_b[1]),
        .collision(collision[1]), .parity_err(parity_err[1])
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] old_word,
                                                 input logic [DW-1:0] new_word,
                                                 input logic [BL-1:0] lanes);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < BL; i++) if (lanes[i]) mask[8*i +: 8] = 8'hFF;
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                exp_v[i][p] = 1'b0;
                exp_d[i][p] = '0;
                exp_k[i][p] = 1'b1;
                for (int s = 0; s < 2; s++) pipe_v[i][p][s] = 1'b0;
            end
        end
        exp_col = 1'b0;
    endtask

    // Instance 0 shows an access after one edge with write-first data, instance 1 after two with old data.
    task automatic model_edge();
        bit            en [2];
        logic [BL-1:0] we [2];
        int            addr [2];
        logic [DW-1:0] din [2];
        bit            dual_write;
        if (!rst_n) begin
            model_reset();
            return;
        end
        en[0] = en_a; we[0] = we_a; addr[0] = int'(addr_a); din[0] = din_a;
        en[1] = en_b; we[1] = we_b; addr[1] = int'(addr_b); din[1] = din_b;
        dual_write = en_a && en_b && (addr_a == addr_b) && (we_a != 0) && (we_b != 0);
        for (int p = 0; p < 2; p++) begin
            bit            inr;
            logic [DW-1:0] old_word, new_word;
            bit            old_k, new_k;
            inr      = addr[p] < DEPTH;
            old_word = inr ? ref_mem[addr[p]] : '0;
            old_k    = !inr || written[addr[p]];
            for (int i = 0; i < 2; i++) begin
                if (i == 0 && inr) begin
                    new_word = merge_word(old_word, din[p], we[p]);
                    new_k    = (old_k || we[p] == 4'hF) && !dual_write;
                end else begin
                    new_word = old_word;
                    new_k    = old_k;
                end
                pipe_v[i][p][1] = pipe_v[i][p][0];
                pipe_d[i][p][1] = pipe_d[i][p][0];
                pipe_k[i][p][1] = pipe_k[i][p][0];
                pipe_v[i][p][0] = en[p];
                if (en[p]) begin
                    pipe_d[i][p][0] = new_word;
                    pipe_k[i][p][0] = new_k;
                end
                exp_v[i][p] = pipe_v[i][p][i];
                if (pipe_v[i][p][i]) begin
                    exp_d[i][p] = pipe_d[i][p][i];
                    exp_k[i][p] = pipe_k[i][p][i];
                end
            end
        end
        for (int p = 1; p >= 0; p--) begin
            if (en[p] && addr[p] < DEPTH) begin
                ref_mem[addr[p]] = merge_word(ref_mem[addr[p]], din[p], we[p]);
                if (we[p] == 4'hF) written[addr[p]] = 1'b1;
            end
        end
        exp_col = en_a && en_b && (addr_a == addr_b) && ((we_a != 0) || (we_b != 0));
    endtask

    task automatic compare(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_output();
        for (int i = 0; i < 2; i++) begin
            compare($sformatf("valid_a[%0d]", i), 32'(valid_a[i]), 32'(exp_v[i][0]));
            compare($sformatf("valid_b[%0d]", i), 32'(valid_b[i]), 32'(exp_v[i][1]));
            if (exp_k[i][0]) compare($sformatf("dout_a[%0d]", i), dout_a[i], exp_d[i][0]);
            if (exp_k[i][1]) compare($sformatf("dout_b[%0d]", i), dout_b[i], exp_d[i][1]);
            compare($sformatf("collision[%0d]", i), 32'(collision[i]), 32'(exp_col));
            compare($sformatf("parity_err[%0d]", i), 32'(parity_err[i]), 32'h0);
        end
    endtask

    task automatic apply_stimulus(input logic ea, input logic [BL-1:0] wa, input logic [AW-1:0] aa,
                                  input logic [DW-1:0] da, input logic eb, input logic [BL-1:0] wb,
                                  input logic [AW-1:0] ab, input logic [DW-1:0] db);
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) written[k] = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) idle();
        rst_n = 1'b1;

        // Write through B so A's output is still at its reset value when the read arrives.
        apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd5, 32'hDEADBEEF);
        apply_stimulus(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        compare("lat1 valid at 1", 32'(valid_a[0]), 32'h1);
        compare("lat1 data at 1", dout_a[0], 32'hDEADBEEF);
        compare("lat2 valid at 1", 32'(valid_a[1]), 32'h0);
        compare("lat2 data at 1", dout_a[1], 32'h0);
        idle();
        compare("lat2 valid at 2", 32'(valid_a[1]), 32'h1);
        compare("lat2 data at 2", dout_a[1], 32'hDEADBEEF);
        compare("lat1 valid drop", 32'(valid_a[0]), 32'h0);
        compare("lat1 data hold", dout_a[0], 32'hDEADBEEF);

        for (int k = 0; k < DEPTH; k++)
            apply_stimulus(1'b1, 4'hF, 4'(k), $urandom, 1'b0, 4'h0, 4'd0, 32'h0);

        apply_stimulus(1'b1, 4'hF, 4'd9, 32'h11223344, 1'b0, 4'h0, 4'd0, 32'h0);
        apply_stimulus(1'b1, 4'b0101, 4'd9, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0);
        apply_stimulus(1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        idle();
        compare("byte lanes lat1", dout_a[0], 32'h11BB33DD);
        compare("byte lanes lat2", dout_a[1], 32'h11BB33DD);

        apply_stimulus(1'b1, 4'hF, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        apply_stimulus(1'b1, 4'hF, 4'd3, 32'h12345678, 1'b0, 4'h0, 4'd0, 32'h0);
        compare("rdw write-first", dout_a[0], 32'h12345678);
        idle();
        compare("rdw read-first", dout_a[1], 32'h00000000);

        apply_stimulus(1'b1, 4'b1100, 4'd7, 32'hAAAA0000, 1'b1, 4'hF, 4'd7, 32'h0000BBBB);
        compare("ww collision lat1", 32'(collision[0]), 32'h1);
        compare("ww collision lat2", 32'(collision[1]), 32'h1);
        idle();
        compare("collision pulse lat2", 32'(collision[1]), 32'h0);
        apply_stimulus(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        idle();
        compare("ww merge lat1", dout_a[0], 32'hAAAABBBB);
        compare("ww merge lat2", dout_a[1], 32'hAAAABBBB);

        apply_stimulus(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
        compare("rr no collision", 32'(collision[0]), 32'h0);
        compare("rr valid_a lat1", 32'(valid_a[0]), 32'h1);
        compare("rr valid_b lat1", 32'(valid_b[0]), 32'h1);
        compare("rr dout_b lat1", dout_b[0], 32'hAAAABBBB);
        idle();
        compare("rr valid_a lat2", 32'(valid_a[1]), 32'h1);
        compare("rr valid_b lat2", 32'(valid_b[1]), 32'h1);
        compare("rr dout_b lat2", dout_b[1], 32'hAAAABBBB);

        apply_stimulus(1'b1, 4'hF, 4'd14, 32'hFFFFFFFF, 1'b0, 4'h0, 4'd0, 32'h0);
        apply_stimulus(1'b1, 4'h0, 4'd14, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        compare("oob valid", 32'(valid_a[0]), 32'h1);
        compare("oob data", dout_a[0], 32'h0);

        // A write presented while reset is held must leave the word untouched.
        apply_stimulus(1'b1, 4'hF, 4'd2, 32'h0BADF00D, 1'b0, 4'h0, 4'd0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        apply_stimulus(1'b1, 4'hF, 4'd2, 32'hFFFFFFFF, 1'b0, 4'h0, 4'd0, 32'h0);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        idle();
        compare("write under reset", dout_a[1], 32'h0BADF00D);

        apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd4, 32'h0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare("mid reset valid_b lat1", 32'(valid_b[0]), 32'h0);
        compare("mid reset dout_b lat1", dout_b[0], 32'h0);
        compare("mid reset valid_b lat2", 32'(valid_b[1]), 32'h0);
        compare("mid reset dout_b lat2", dout_b[1], 32'h0);
        #2 rst_n = 1'b1;
        idle();
        compare("discarded read valid_b", 32'(valid_b[1]), 32'h0);
        compare("discarded read dout_b", dout_b[1], 32'h0);

        for (int n = 0; n < 400; n++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                           4'($urandom_range(0, 15)), $urandom,
                           1'($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                           4'($urandom_range(0, 15)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
